// File: rtl/pixel_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pixel_scan_scheduler
// Purpose  : Raster pixel sequencer for the path tracer, with a tag delay line
//            that names the pixel whose tracer result is valid each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_scan_scheduler #(
  parameter int H_RES    = 800,
  parameter int V_RES    = 600,
  parameter int CW       = 10,
  parameter int PIPE_LAT = 8
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          pix_valid,
  output logic          busy,
  output logic          res_valid,
  output logic [CW-1:0] res_x,
  output logic [CW-1:0] res_y,
  output logic          res_last,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] c_x_last = CW'(H_RES - 1);
  localparam logic [CW-1:0] c_y_last = CW'(V_RES - 1);
  localparam int            c_tail   = PIPE_LAT - 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          w_pix_valid;
  logic          w_is_last;
  logic          w_busy;
  logic          w_frame_done;

  logic [PIPE_LAT-1:0] r_dl_valid;
  logic [PIPE_LAT-1:0] r_dl_last;
  logic [CW-1:0]       r_dl_x [PIPE_LAT];
  logic [CW-1:0]       r_dl_y [PIPE_LAT];

  assign w_is_last = (r_x == c_x_last) && (r_y == c_y_last);

  always_comb begin
    w_state_nxt  = r_state;
    w_pix_valid  = 1'b0;
    w_busy       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stall) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        w_busy      = 1'b1;
        w_pix_valid = !stall;
        if (!stall && w_is_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (res_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Counters return to (0,0) after the final pixel so they read 0 once idle.
  always_ff @(posedge sysclk) begin
    if (rst || r_state == S_IDLE) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pix_valid) begin
      if (w_is_last) begin
        r_x <= '0;
        r_y <= '0;
      end else if (r_x == c_x_last) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_dl_valid <= '0;
      r_dl_last  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_dl_x[i] <= '0;
        r_dl_y[i] <= '0;
      end
    end else if (!stall) begin
      r_dl_valid[0] <= w_pix_valid;
      r_dl_last[0]  <= w_pix_valid & w_is_last;
      r_dl_x[0]     <= r_x;
      r_dl_y[0]     <= r_y;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_last[i]  <= r_dl_last[i-1];
        r_dl_x[i]     <= r_dl_x[i-1];
        r_dl_y[i]     <= r_dl_y[i-1];
      end
    end
  end

  assign pixel_x    = r_x;
  assign pixel_y    = r_y;
  assign pix_valid  = w_pix_valid;
  assign busy       = w_busy;
  assign frame_done = w_frame_done;
  // A held tail must not be reported twice while the tracer is stalled.
  assign res_valid  = r_dl_valid[c_tail] & ~stall;
  assign res_x      = r_dl_x[c_tail];
  assign res_y      = r_dl_y[c_tail];
  assign res_last   = r_dl_last[c_tail] & res_valid;

endmodule
`default_nettype wire
